serial_subtractor: RTL and testbench



---
 rtl/sub_defs.sv | 10 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_defs.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings.
package sub_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell, combinational (zero latency, no flow control).
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = x - y - b_in, LSB first; accept->done = W+1 cycles, one op per W+2.
// start is taken only while ready=1 (no queuing); SERIAL_SUB_OVF_EN adds the ovf output.
module serial_subtractor
  import sub_defs::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         b_in,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] d,
  output logic         b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_nxt;
  logic          load, shift_en, last;
  logic [CW-1:0] count;
  logic [W-1:0]  x_sr, y_sr, res;
  logic          br;
  logic          bit_d, bit_b;

  full_subtractor u_cell (
    .x     (x_sr[0]),
    .y     (y_sr[0]),
    .b_in  (br),
    .d     (bit_d),
    .b_out (bit_b)
  );

  assign last = (count == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        shift_en = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result enters from the MSB side so after W shifts bit 0 sits at res[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      x_sr  <= '0;
      y_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      count <= '0;
    end else if (load) begin
      x_sr  <= x;
      y_sr  <= y;
      br    <= b_in;
      count <= '0;
    end else if (shift_en) begin
      x_sr  <= x_sr >> 1;
      y_sr  <= y_sr >> 1;
      br    <= bit_b;
      res   <= {bit_d, res[W-1:1]};
      count <= count + CW'(1);
    end
  end

  assign d     = res;
  assign b_out = br;

`ifdef SERIAL_SUB_OVF_EN
  logic x_msb, y_msb, ovf_r;

  // The last serial bit is the result MSB, so overflow is settled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf_r <= 1'b0;
    end else if (load) begin
      x_msb <= x[W-1];
      y_msb <= y[W-1];
    end else if (shift_en && last) begin
      ovf_r <= (x_msb ^ y_msb) & (bit_d ^ x_msb);
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=3); reference model uses plain integer arithmetic.
module tb_serial_subtractor;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x, y;
  logic         b_in;
  logic         ready, done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer result, then reduced to W bits / signed range.
  function automatic logic [W-1:0] ref_d(input int xa, input int ya, input int ba);
    int diff;
    diff = xa - ya - ba;
    return diff[W-1:0];
  endfunction

  function automatic logic ref_b(input int xa, input int ya, input int ba);
    return (xa - ya - ba) < 0;
  endfunction

  function automatic logic ref_ovf(input int xa, input int ya, input int ba);
    int sx, sy, sd;
    sx = (xa >= 2**(W-1)) ? xa - 2**W : xa;
    sy = (ya >= 2**(W-1)) ? ya - 2**W : ya;
    sd = sx - sy - ba;
    return (sd < -(2**(W-1))) || (sd > 2**(W-1) - 1);
  endfunction

  task automatic check_result(input string tag, input int xa, input int ya, input int ba);
    chk({tag, "_d"}, 32'(d), 32'(ref_d(xa, ya, ba)));
    chk({tag, "_bout"}, 32'(b_out), 32'(ref_b(xa, ya, ba)));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(xa, ya, ba)));
`endif
  endtask

  // One operation from IDLE; operands are scrambled right after accept.
  task automatic do_op(input string tag, input int xa, input int ya, input int ba);
    int  n;
    bit  seen;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
    start = 1'b1;
    x     = W'(xa);
    y     = W'(ya);
    b_in  = 1'(ba);
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    b_in  = ~b_in;
    n     = 0;
    seen  = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W + 1));
    chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    check_result(tag, xa, ya, ba);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_post"}, 32'(ready), 32'd1);
    check_result({tag, "_held"}, xa, ya, ba);
  endtask

  initial begin
    logic [2*W:0] q[$];
    logic [2*W:0] e;
    int cyc, last_done, ndone, seen_done;

    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    b_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;

    do_op("op_5m3", 5, 3, 0);
    do_op("op_3m5", 3, 5, 0);
    do_op("op_wrap", 0, 0, 1);
    do_op("op_3m4", 3, 4, 0);
    do_op("op_2m1", 2, 1, 0);
    do_op("op_7m7b", 7, 7, 1);
    for (int i = 0; i < 16; i++)
      do_op("op_rand", int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)),
            int'($urandom_range(0, 1)));

    // start held high: accepts only when ready, one done every W+2 cycles.
    cyc       = 0;
    last_done = -1;
    ndone     = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (last_done >= 0) chk("cont_spacing", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
        if (q.size() > 0) begin
          e = q.pop_front();
          check_result("cont", int'(e[2*W:W+1]), int'(e[W:1]), int'(e[0]));
        end else begin
          chk("cont_spurious_done", 32'd1, 32'd0);
        end
      end
      start = (cyc <= 40);
      x     = W'($urandom);
      y     = W'($urandom);
      b_in  = 1'($urandom);
      if (ready && start) q.push_back({x, y, b_in});
    end
    start = 1'b0;
    chk("cont_ndone", 32'(ndone >= 7), 32'd1);
    chk("cont_queue_empty", 32'(q.size()), 32'd0);

    // Reset during RUN cycle 2 aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    x     = 3'd6;
    y     = 3'd1;
    b_in  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bout", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", 32'(ovf), 32'd0);
`endif
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    do_op("op_after_abort", 1, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
